// File: rtl/rcs40_seq.sv
// Multi-cycle subtractor: D = A - B - Bin, one DIGIT-wide slice per clock, LSB first.
// Valid/ready handshakes on both sides; results are held in output registers until taken.
module rcs40_seq #(
    parameter int WIDTH = 40,
    parameter int DIGIT = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] D,
    output logic             Bout,
    output logic             Z,
    output logic             V
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_r, b_r, diff_r, diff_nxt;
    logic             borrow;
    logic [DIGIT-1:0] a_sl, b_sl, d_sl;
    logic             c_sl;
    logic             accept, last;

    assign accept    = (state == IDLE) && in_valid;
    assign last      = (state == RUN) && (cnt == LAST);
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // Slice k: A + ~B + ~borrow; the carry-out is the inverted borrow.
    always_comb begin
        a_sl = a_r[cnt*DIGIT +: DIGIT];
        b_sl = b_r[cnt*DIGIT +: DIGIT];
        {c_sl, d_sl} = {1'b0, a_sl} + {1'b0, ~b_sl} + {{DIGIT{1'b0}}, ~borrow};
        diff_nxt = diff_r;
        diff_nxt[cnt*DIGIT +: DIGIT] = d_sl;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = RUN;
            RUN:     if (last)      state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r    <= '0;
            b_r    <= '0;
            diff_r <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
            D      <= '0;
            Bout   <= 1'b0;
            Z      <= 1'b0;
            V      <= 1'b0;
        end else if (accept) begin
            a_r    <= A;
            b_r    <= B;
            borrow <= Bin;
            cnt    <= '0;
        end else if (state == RUN) begin
            diff_r <= diff_nxt;
            borrow <= ~c_sl;
            // Wrap to 0 so the slice index never leaves the operand range.
            cnt    <= last ? '0 : cnt + CW'(1);
            if (last) begin
                D    <= diff_nxt;
                Bout <= ~c_sl;
                Z    <= (diff_nxt == '0);
                V    <= (a_r[WIDTH-1] ^ b_r[WIDTH-1]) & (diff_nxt[WIDTH-1] ^ a_r[WIDTH-1]);
            end
        end
    end
endmodule

// File: doc/rcs40_seq.md
Name: rcs40_seq

Overview:
- Multi-cycle 40-bit subtractor: D = A - B - Bin, plus borrow-out and status flags.
- Subtraction counterpart to the team's ripple-carry adder datapath.
- Processes one DIGIT-wide slice per clock, LSB slice first, so the combinational borrow chain stays DIGIT bits long.
- Sits behind a valid/ready input handshake and a valid/ready output handshake.

Parameters:
WIDTH, 40, operand and result width in bits.
DIGIT, 8, bits processed per cycle. WIDTH must be an integer multiple of DIGIT. N = WIDTH/DIGIT (5 by default).

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands and Bin are valid
in_ready  output  1  block can accept an operation
A  input  WIDTH  minuend
B  input  WIDTH  subtrahend
Bin  input  1  borrow into LSB
out_valid  output  1  result is valid
out_ready  input  1  consumer accepts the result
D  output  WIDTH  difference, A - B - Bin mod 2^WIDTH
Bout  output  1  final borrow: 1 when A < B + Bin (unsigned)
Z  output  1  D equals 0
V  output  1  signed two's-complement overflow of A - B - Bin

Behaviour:
- Reset: asynchronous on rst_n low. Reset values:
  - state = IDLE
  - D = 0, Bout = 0, Z = 0, V = 0, out_valid = 0
  - internal counter, borrow and working registers = 0
  - in_ready = 1 (decoded from IDLE)
- Reset asserted mid-operation aborts it. No out_valid is produced for the aborted operation.
- IDLE:
  - in_ready = 1.
  - On a clock edge with in_valid = 1, capture A, B and Bin into working registers, set cnt = 0, go to RUN.
- RUN:
  - in_ready = 0.
  - Each edge processes slice k = cnt: {b, d} = A[k*DIGIT +: DIGIT] - B[k*DIGIT +: DIGIT] - borrow.
  - Write d into the working difference register slice k; borrow <= b; cnt <= cnt + 1.
  - The slice is computed as A + ~B + ~borrow, with carry-out inverted to give the borrow.
  - On the edge where cnt = N-1 is processed, go to DONE and load the output registers:
    - D = full working difference
    - Bout = final borrow
    - Z = (D == 0)
    - V = (A[W-1] ^ B[W-1]) & (D[W-1] ^ A[W-1]), using the captured A and B
  - out_valid rises on that same edge.
- Latency: out_valid is high exactly N cycles after the accepting edge (5 cycles at default parameters).
- DONE:
  - out_valid = 1, in_ready = 0.
  - D, Bout, Z and V are held stable until the edge where out_ready = 1. On that edge go to IDLE and drop out_valid.
  - Throughput: at most one operation per N+2 cycles. No overlap of accept and result handoff.
- Output stability: D, Bout, Z and V change only on entry to DONE. They hold the last result, or reset values, in IDLE and RUN.
- in_valid in RUN or DONE is ignored. A, B and Bin may change freely after acceptance.
- Bin = 1 with A = B yields all-ones D and Bout = 1.
- Borrow propagates across slice boundaries through the registered borrow only.

Test Plan:
- Basic subtraction: A=0x00_0000_0005, B=0x00_0000_0003, Bin=0 -> D=0x00_0000_0002, Bout=0, Z=0, V=0. out_valid exactly 5 cycles after the accept edge.
- Underflow: A=0, B=1, Bin=0 -> D=0xFF_FFFF_FFFF, Bout=1, Z=0, V=0.
- Equal operands: A=B=0x12_3456_789A, Bin=0 -> D=0, Z=1, Bout=0. Repeat with Bin=1 -> D=0xFF_FFFF_FFFF, Bout=1, Z=0.
- Cross-slice borrow ripple and signed overflow:
  - A=0x01_0000_0000, B=1 -> D=0x00_FFFF_FFFF, Bout=0.
  - A=0x80_0000_0000, B=1 -> D=0x7F_FFFF_FFFF, V=1, Bout=0.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> D, Bout, Z, V and out_valid stay stable, in_ready=0, and a pulsed in_valid is ignored. Raise out_ready -> out_valid falls next edge, in_ready=1.
- Reset mid-RUN: pulse rst_n low after 2 slices -> immediately out_valid=0, D=0, in_ready=1. A following A=7, B=2 operation returns D=5 with correct 5-cycle latency.
